// File: rtl/pulse_envelope_detector_pkg.sv
// pulse_envelope_detector_pkg: shared detector state type and saturating magnitude helper
package pulse_envelope_detector_pkg;
  typedef enum logic {QUIET, ACTIVE} state_t;
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int dw);
    logic signed [31:0] lim;
    lim = (1 <<< (dw - 1)) - 1;
    return x < 0 ? (x < -lim ? lim : -x) : x;
  endfunction
endpackage

// File: rtl/moving_sum.sv
// moving_sum: running sum of the last 2**WIN_LOG2 magnitudes
module moving_sum #(
  parameter int DW = 16,
  parameter int WIN_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-2:0]            mag_i,
  input  logic                     valid_i,
  output logic [DW-2+WIN_LOG2:0]   sum_o,
  output logic                     valid_o
);
  localparam int WIN = 1 << WIN_LOG2;
  localparam int SW = DW - 1 + WIN_LOG2;
  logic [DW-2:0] window [WIN];
  // shift the new magnitude in and swap it for the oldest in the sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) window[i] <= '0;
      sum_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        window[0] <= mag_i;
        for (int i = 1; i < WIN; i++) window[i] <= window[i-1];
        sum_o <= sum_o + SW'(mag_i) - SW'(window[WIN-1]);
      end
    end
endmodule

// File: rtl/pulse_envelope_detector.sv
// pulse_envelope_detector: moving-average envelope with hysteresis pulse detection and timing
module pulse_envelope_detector
  import pulse_envelope_detector_pkg::*;
#(
  parameter int DW = 16,
  parameter int WIN_LOG2 = 4,
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] data_i,
  input  logic                 valid_i,
  input  logic [DW-2:0]        thr_on_i,
  input  logic [DW-2:0]        thr_off_i,
  output logic [DW-2:0]        env_o,
  output logic                 env_valid_o,
  output logic                 det_o,
  output logic                 start_o,
  output logic                 end_o,
  output logic [CNT_W-1:0]     width_o,
  output logic [CNT_W-1:0]     period_o
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [DW-2:0] mag;
  logic mag_valid;
  logic [DW-2+WIN_LOG2:0] sum;
  state_t state, state_n;
  logic start_n, end_n, first;
  logic [CNT_W-1:0] wcnt, icnt;
  // stage 1: saturating magnitude of each accepted sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= valid_i;
      if (valid_i) mag <= (DW-1)'(sat_abs(32'(data_i), DW));
    end
  moving_sum #(.DW(DW), .WIN_LOG2(WIN_LOG2)) u_sum (
    .clk(clk), .rst_n(rst_n), .mag_i(mag), .valid_i(mag_valid),
    .sum_o(sum), .valid_o(env_valid_o)
  );
  assign env_o = (DW-1)'(sum >> WIN_LOG2);
  assign det_o = state == ACTIVE;
  // hysteresis decision, one transition at most per envelope update
  always_comb begin
    state_n = state;
    start_n = 1'b0;
    end_n = 1'b0;
    if (env_valid_o && state == QUIET && env_o >= thr_on_i) begin
      state_n = ACTIVE;
      start_n = 1'b1;
    end else if (env_valid_o && state == ACTIVE && env_o < thr_off_i) begin
      state_n = QUIET;
      end_n = 1'b1;
    end
  end
  // state and registered start/end strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= QUIET;
      start_o <= 1'b0;
      end_o <= 1'b0;
    end else begin
      state <= state_n;
      start_o <= start_n;
      end_o <= end_n;
    end
  // saturating width and start-to-start counters, latched on strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      icnt <= '0;
      first <= 1'b1;
      width_o <= '0;
      period_o <= '0;
    end else if (env_valid_o) begin
      icnt <= start_n ? CNT_W'(1) : (icnt == CMAX ? icnt : icnt + CNT_W'(1));
      if (start_n) begin
        period_o <= first ? '0 : icnt;
        first <= 1'b0;
        wcnt <= CNT_W'(1);
      end else if (state == ACTIVE && !end_n) wcnt <= wcnt == CMAX ? wcnt : wcnt + CNT_W'(1);
      if (end_n) width_o <= wcnt;
    end
endmodule

// File: doc/pulse_envelope_detector.md
Name: pulse_envelope_detector

Overview:
- Sits directly downstream of the pulsed-sine source / ADC sample stream and consumes a signed sample stream with a valid strobe.
- Computes a moving-average magnitude envelope over a power-of-two window and detects pulses with hysteresis thresholds.
- Per pulse, reports start/end strobes, pulse width and start-to-start interval, all in sample units. Feeds the receiver's pulse-timing logic.

Parameters:
- DW, 16, input sample width (signed two's complement).
- WIN_LOG2, 4, log2 of moving-average window length (WIN = 2**WIN_LOG2 samples).
- CNT_W, 24, width of the width and interval counters and outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  DW  signed sample.
- valid_i  in  1  sample strobe; data_i is accepted on any clk edge with valid_i=1.
- thr_on_i  in  DW-1  envelope level at or above which a pulse starts (unsigned).
- thr_off_i  in  DW-1  envelope level below which a pulse ends (unsigned).
- env_o  out  DW-1  current envelope (mean |x| over window).
- env_valid_o  out  1  one-cycle strobe, env_o updated.
- det_o  out  1  high while in ACTIVE state.
- start_o  out  1  one-cycle strobe, pulse start detected.
- end_o  out  1  one-cycle strobe, pulse end detected.
- width_o  out  CNT_W  width of last completed pulse; valid with end_o, held after.
- period_o  out  CNT_W  samples since previous start; valid with start_o, held after.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, window buffer and running sum cleared, FSM=QUIET, first-pulse flag set. Reset mid-pulse abandons the pulse silently; no end_o is emitted.
- Stage 1 (t+1 after valid_i at t): mag = |data_i|. The most negative value saturates to 2**(DW-1)-1. mag_valid is registered.
- Stage 2 (t+2): sum <= sum + mag - oldest. The oldest magnitude comes from a WIN-deep shift buffer (zeros after reset). sum width is DW-1+WIN_LOG2, so it cannot overflow. env_o = sum >> WIN_LOG2 (floor). env_valid_o pulses at t+2.
- Stage 3 (t+3): the FSM evaluates on each env_valid, compares against the registered env, and produces registered strobes and det_o. Total latency from valid_i to start_o/end_o is 3 cycles.
- Back-to-back valid_i on every cycle is supported with full throughput. Gaps in valid_i are allowed; the pipeline advances only on valid.
- FSM transitions:
  - QUIET -> ACTIVE when env >= thr_on. Emits start_o. width counter := 1.
  - ACTIVE -> QUIET when env < thr_off. Emits end_o. width_o := width counter, counting env updates from the start update through the last update before the end update.
  - In ACTIVE with no end, width counter increments per env update.
- Interval counter:
  - Increments on every env update.
  - At start_o: period_o := counter, then counter := 1.
  - First start after reset: period_o := 0, and the first-pulse flag clears.
- Both counters saturate at 2**CNT_W-1 and never wrap.
- start_o and end_o are never asserted in the same cycle. A start is only evaluated from QUIET, so an end and a re-start need at least two env updates.
- If thr_on < thr_off, the transition checks still apply as written. Each env update causes at most one transition, so the FSM cannot oscillate within a cycle.
- Threshold inputs are sampled at evaluation time and may change at any time.

Decomposition:
- Shared dsp package: state enum (QUIET, ACTIVE) and a saturating-abs function.
- One sub-module, moving_sum: parameters DW, WIN_LOG2; ports clk, rst_n, mag_i, valid_i, sum_o, valid_o. Contains the shift buffer and the running sum.
- The FSM and counters live in the top-level module.

Test Plan (DW=16, WIN_LOG2=4, CNT_W=24, thr_on=500, thr_off=250, valid_i every cycle):
- Reset -> all outputs 0. With zero input for 40 samples: env_o=0, no strobes.
- 50 samples of +1000 then zeros -> start_o 3 cycles after the 8th +1000 sample (env 500). end_o after the 13th zero (env 187). width_o=55.
- Same pattern with -1000 samples -> identical timing and width. With -32768 input: mag=32767, no overflow, env_o saturates at 32767.
- Two 50-sample pulses whose starts are 100 samples apart -> first start_o gives period_o=0, second gives period_o=100.
- Amplitude 400 (env peaks at 400 < 500) -> no start_o. Pulse at 1000, then hold at 300 (env settles 300 >= 250) -> det_o stays high, no end_o.
- Assert rst_n low mid-pulse (det_o=1) -> det_o=0 immediately, no end_o. Next start after release gives period_o=0.
- valid_i toggled every 3rd cycle with the same +1000 pattern -> same width_o=55, strobes 3 cycles after the triggering valid.
